// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: mode encoding,
// lookahead group size and the stage-count helper.
package pipelined_cla_adder_pkg;

   localparam logic MODE_ADD   = 1'b0;
   localparam logic MODE_SUB   = 1'b1;
   localparam int   GROUP_BITS = 4;

   function automatic int num_stages(input int width, input int groups);
      return width / (GROUP_BITS * groups);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group4.sv
// 4-bit carry-lookahead group: purely combinational sum plus group generate/propagate.
// No state, no flow control; the enclosing pipeline stage registers the results.
module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       gg,
   output logic       gp
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c;
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign gp = &p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA add/sub, L = WIDTH/(4*STAGE_GROUPS) register stages of latency.
// Global stall: every stage holds while the output beat is valid and not accepted.
module pipelined_cla_adder
   import pipelined_cla_adder_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int STAGE_GROUPS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = GROUP_BITS * STAGE_GROUPS;
   localparam int L  = num_stages(WIDTH, STAGE_GROUPS);

   // Stage k keeps only the operand bits above its slice and only the sum bits
   // below it, so each stage's fields are packed back to back at these offsets.
   function automatic int op_off(input int k);
      int o = 0;
      for (int i = 0; i < k; i++) o += WIDTH - (i + 1) * SW;
      return o;
   endfunction

   function automatic int sum_off(input int k);
      int o = 0;
      for (int i = 0; i < k; i++) o += (i + 1) * SW;
      return o;
   endfunction

   localparam int OP_BITS  = (op_off(L - 1) > 0) ? op_off(L - 1) : 1;
   localparam int SUM_BITS = (sum_off(L - 1) > 0) ? sum_off(L - 1) : 1;
   localparam int MID      = (L > 1) ? L - 1 : 1;

   if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of 4*STAGE_GROUPS");
   end

   logic [WIDTH-1:0]    b_eff;
   logic                c_in_eff;
   logic                advance;
   logic [L-1:0]        vld_q;
   logic [L-1:0]        cry_q;
   logic [OP_BITS-1:0]  opa_q;
   logic [OP_BITS-1:0]  opb_q;
   logic [SUM_BITS-1:0] part_q;
   logic [MID-1:0]      sa_q;
   logic [MID-1:0]      sb_q;
   logic [WIDTH-1:0]    s_q;
   logic                ovf_q;
   logic                zero_q;

   assign b_eff    = (sub == MODE_SUB) ? ~b : b;
   assign c_in_eff = (sub == MODE_ADD) ? cin : 1'b1;

   assign advance  = ~vld_q[L-1] | out_ready;
   assign in_ready = advance & ~rst;

   for (genvar k = 0; k < L; k++) begin : g_stage
      localparam int REM = WIDTH - k * SW;

      logic [REM-1:0]          a_src;
      logic [REM-1:0]          b_src;
      logic                    c_src;
      logic                    sa_src;
      logic                    sb_src;
      logic                    v_src;
      logic [SW-1:0]           s_slice;
      logic [(k+1)*SW-1:0]     sum_new;
      logic [STAGE_GROUPS:0]   gc;

      if (k == 0) begin : g_head
         assign a_src   = a;
         assign b_src   = b_eff;
         assign c_src   = c_in_eff;
         assign sa_src  = a[WIDTH-1];
         assign sb_src  = b_eff[WIDTH-1];
         assign v_src   = in_valid;
         assign sum_new = s_slice;
      end else begin : g_body
         assign a_src   = opa_q[op_off(k-1) +: REM];
         assign b_src   = opb_q[op_off(k-1) +: REM];
         assign c_src   = cry_q[k-1];
         assign sa_src  = sa_q[k-1];
         assign sb_src  = sb_q[k-1];
         assign v_src   = vld_q[k-1];
         assign sum_new = {s_slice, part_q[sum_off(k-1) +: k*SW]};
      end

      // Groups inside a stage link only through their Gg/Pg, never by bit ripple.
      assign gc[0] = c_src;
      for (genvar j = 0; j < STAGE_GROUPS; j++) begin : g_grp
         logic gg;
         logic gp;

         cla_group4 u_grp (
            .a  (a_src[4*j +: 4]),
            .b  (b_src[4*j +: 4]),
            .ci (gc[j]),
            .s  (s_slice[4*j +: 4]),
            .gg (gg),
            .gp (gp)
         );

         assign gc[j+1] = gg | (gp & gc[j]);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[k] <= 1'b0;
            cry_q[k] <= 1'b0;
         end else if (advance) begin
            vld_q[k] <= v_src;
            cry_q[k] <= gc[STAGE_GROUPS];
         end
      end

      if (k < L - 1) begin : g_fwd
         localparam int NXT = REM - SW;

         always_ff @(posedge clk) begin
            if (rst) begin
               opa_q[op_off(k) +: NXT]        <= '0;
               opb_q[op_off(k) +: NXT]        <= '0;
               part_q[sum_off(k) +: (k+1)*SW] <= '0;
               sa_q[k]                        <= 1'b0;
               sb_q[k]                        <= 1'b0;
            end else if (advance) begin
               opa_q[op_off(k) +: NXT]        <= a_src[REM-1:SW];
               opb_q[op_off(k) +: NXT]        <= b_src[REM-1:SW];
               part_q[sum_off(k) +: (k+1)*SW] <= sum_new;
               sa_q[k]                        <= sa_src;
               sb_q[k]                        <= sb_src;
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk) begin
            if (rst) begin
               s_q    <= '0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               s_q    <= sum_new;
               ovf_q  <= (sa_src == sb_src) & (sum_new[WIDTH-1] != sa_src);
               zero_q <= ~|sum_new;
            end
         end
      end
   end

   assign out_valid = vld_q[L-1];
   assign cout      = cry_q[L-1];
   assign s         = s_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: 32-bit default instance plus an 8-bit, L=2 instance.
module tb_pipelined_cla_adder;

   localparam int L = 4;
   localparam longint MAXS = 64'sh7FFFFFFF;
   localparam longint MINS = -64'sh80000000;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, sub;
   logic        out_valid, out_ready, cout, ovf, zero;
   logic [31:0] a, b, s;

   logic        in_valid8, in_ready8, cin8, sub8;
   logic        out_valid8, out_ready8, cout8, ovf8, zero8;
   logic [7:0]  a8, b8, s8;

   exp_t        q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic        held = 1'b0;
   logic [34:0] held_val;
   logic        rand_done = 1'b0;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(32), .STAGE_GROUPS(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf), .zero(zero)
   );

   pipelined_cla_adder #(.WIDTH(8), .STAGE_GROUPS(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference via signed 64-bit arithmetic; borrow-free subtract means a >= b.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tc, input logic ts);
      exp_t   r;
      longint ra, rb, rr;
      logic [32:0] u;
      ra = longint'($signed(ta));
      rb = longint'($signed(tb));
      rr = ts ? ra - rb : ra + rb + longint'(tc);
      u  = {1'b0, ta} + {1'b0, tb} + 33'(tc);
      r.s = rr[31:0];
      r.c = ts ? (ta >= tb) : u[32];
      r.v = (rr > MAXS) || (rr < MINS);
      r.z = (rr[31:0] == 32'd0);
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc, input logic ts);
      int   n  = 0;
      logic ok = 1'b0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else n++;
      end
      if (!ok) chk("in_ready_timeout", in_ready, 1'b1);
      else q.push_back(model(ta, tb, tc, ts));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic lat_check(input string tag);
      repeat (L - 2) @(posedge clk);
      #1 chk({tag, "_early"}, out_valid, 1'b0);
      @(posedge clk);
      #1 chk(tag, out_valid, 1'b1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk(tag, q.size(), 0);
   endtask

   // Output monitor: pops on every handshake, checks a stalled beat never changes.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (out_valid) begin
         if (held) chk("hold_stable", {s, cout, ovf, zero}, held_val);
         if (out_ready) begin
            held = 1'b0;
            if (q.size() == 0) begin
               chk("stale_beat", out_valid, 1'b0);
            end else begin
               e = q.pop_front();
               chk("s", s, e.s);
               chk("cout", cout, e.c);
               chk("ovf", ovf, e.v);
               chk("zero", zero, e.z);
            end
         end else begin
            held     = 1'b1;
            held_val = {s, cout, ovf, zero};
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", s, 32'd0);
      chk("rst_flags", {cout, ovf, zero}, 3'b000);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid8", out_valid8, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Carry rippling through every stage, with exact latency.
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      lat_check("t1_lat");
      repeat (4) @(posedge clk); #1;

      send(32'd5, 32'd7, 1'b0, 1'b1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      send(32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1);
      send(32'h0000_00FF, 32'h0000_0F00, 1'b1, 1'b0);
      repeat (8) @(posedge clk); #1;

      fork
         begin
            for (int i = 1; i <= 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
         end
         begin
            int n = 0;
            while (!out_valid && n < 50) begin
               @(posedge clk); #1;
               n++;
            end
            chk("t4_first_out", out_valid, 1'b1);
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("t4_in_ready", in_ready, 1'b0);
               chk("t4_s_hold", s, 32'd2);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("t4_drain");
      repeat (4) @(posedge clk); #1;

      // Reset with three beats in flight; none may ever surface.
      send(32'd10, 32'd20, 1'b0, 1'b0);
      send(32'd30, 32'd40, 1'b0, 1'b0);
      send(32'd50, 32'd60, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_in_ready_rst", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_s", s, 32'd0);
      chk("t5_flags", {cout, ovf, zero}, 3'b000);
      q.delete();
      rst = 1'b0;
      send(32'd1, 32'd1, 1'b0, 1'b0);
      lat_check("t5_lat");
      repeat (10) @(posedge clk); #1;
      chk("t5_no_stale", q.size(), 0);

      // Narrow instance: L=2.
      a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      chk("t6_in_ready", in_ready8, 1'b1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      chk("t6_early", out_valid8, 1'b0);
      @(posedge clk); #1;
      chk("t6_valid", out_valid8, 1'b1);
      chk("t6_s", s8, 8'h01);
      chk("t6_cout", cout8, 1'b1);
      chk("t6_ovf", ovf8, 1'b0);
      chk("t6_zero", zero8, 1'b0);
      @(posedge clk); #1;
      chk("t6_single", out_valid8, 1'b0);

      // Random traffic with random backpressure.
      fork
         begin
            for (int i = 0; i < 150; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
            drain("rand_drain");
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Operands enter through a valid/ready handshake. The carry chain is cut into register stages, each covering a fixed number of 4-bit groups. Results leave through a second valid/ready handshake with carry, signed-overflow and zero flags. It is the wide-datapath successor to the 4-bit lookahead adder and serves as the ALU add/sub unit.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4·STAGE_GROUPS.
- STAGE_GROUPS, 2, number of 4-bit lookahead groups resolved per pipeline stage.
- Derived constant L = WIDTH/(4·STAGE_GROUPS): number of register stages, which is also the latency.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0 selects a+b+cin; 1 selects a−b.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum or difference.
- cout  out  1  carry out of the MSB (raw carry; in subtract mode 1 means no borrow).
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.

## Operation
- Operand preparation: b_eff = sub ? ~b : b; c_in_eff = sub ? 1 : cin.
- Stage k (k = 0..L−1) handles bits [4·STAGE_GROUPS·(k+1)−1 : 4·STAGE_GROUPS·k].
- Inside a stage, the groups are chained by group generate/propagate: Gg = g3|p3g2|p3p2g1|p3p2p1g0, Pg = p3p2p1p0. No ripple crosses a group boundary within a stage except through this lookahead.
- Stage k registers:
  - its sum slice,
  - the carry out of the stage,
  - the still-unprocessed upper operand bits (a, b_eff),
  - the already-computed lower sum bits,
  - the sign bits of a and b_eff,
  - one valid bit.
- Flags are computed in the last stage: ovf = (a_msb == b_eff_msb) & (s_msb != a_msb); zero = ~|s.
- Outputs come directly from the last stage register. No combinational path runs from a/b to s.
- Flow control uses a global stall: advance = ~out_valid | out_ready.
  - All stage registers, including valid bits, load only when advance = 1.
  - in_ready = advance & ~rst.
  - Bubbles are not collapsed. A stalled pipeline holds every stage.
- Beats are never dropped or duplicated and leave in acceptance order.

## Timing
- A beat is accepted on an edge where in_valid & in_ready = 1.
- Latency: a beat accepted at edge n is presented at the outputs after edge n+L−1 if no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- s, cout, ovf and zero are stable while out_valid=1 & out_ready=0.
- Simultaneous output pop and input accept in the same cycle is legal and sustains full rate.
- Reset: on an edge with rst=1, all valid bits and all data registers clear.
  - After that edge: out_valid=0, s=0, cout=0, ovf=0, zero=0.
  - in_ready=0 while rst=1.
  - Beats in flight when reset is asserted mid-operation are discarded.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only on cout.

## Structure
- The shared package (common include) holds:
  - the sub-mode encoding constants (ADD=0, SUB=1),
  - the group-size constant (4),
  - a function computing L from WIDTH and STAGE_GROUPS.
- The sub-module is cla_group4, a 4-bit lookahead group.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], group generate gg, group propagate gp.
  - It is instantiated STAGE_GROUPS times per stage by a generate loop.
- Elaboration fails if WIDTH mod (4·STAGE_GROUPS) ≠ 0.

## Test plan
Test cases 1–5 use the defaults (WIDTH=32, L=4).
1. a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, accepted at edge 0 → after edge 3: s=0x00000000, cout=1, ovf=0, zero=1, out_valid=1. This exercises a carry crossing every stage.
2. a=5, b=7, sub=1 → s=0xFFFFFFFE, cout=0, ovf=0, zero=0.
3. a=0x7FFFFFFF, b=0x00000001, cin=0 → s=0x80000000, ovf=1, cout=0. Also a=0x80000000, b=1, sub=1 → s=0x7FFFFFFF, ovf=1, cout=1.
4. Push 8 beats a=i, b=i, cin=0 (i=1..8) back-to-back; hold out_ready=0 from the cycle the first result appears for 5 cycles.
   - in_ready=0 during the stall.
   - The first output stays stable at s=2.
   - After release, s=2,4,…,16 are delivered in order, with no loss or duplicates.
5. Accept 3 beats, then assert rst for one cycle → after the reset edge, out_valid=0, s=0, and no stale beat ever appears. A new beat 1+1 yields s=2 four cycles later.
6. WIDTH=8, STAGE_GROUPS=1 (L=2): a=0xF0, b=0x10, cin=1 → s=0x01, cout=1, ovf=0, valid after edge n+1.
